// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared opcode, word and request-state types for the data memory path
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [5:0] {
        NOP  = 6'b000000,
        LW   = 6'b100011,
        SW   = 6'b101011,
        LL   = 6'b110000,
        SC   = 6'b111000,
        HALT = 6'b111111
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DREAD  = 3'd1,
        DWRITE = 3'd2,
        DONE   = 3'd3,
        HALTED = 3'd4
    } reqstate_t;

    function automatic logic is_read_op(input opcode_t op);
        return (op == LW) || (op == LL);
    endfunction

endpackage

// File: rtl/mem_request_unit_link_reg.sv
// rtl/mem_request_unit_link_reg.sv - LL/SC link register with coherence snoop invalidation
module link_reg #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clear,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr,
    input  logic [ADDR_W-1:0] match_addr,
    output logic              match
);

    logic              link_valid;
    logic [ADDR_W-1:0] link_addr;

    // A snoop hitting the address being linked this very cycle must leave the link invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (set) begin
            link_addr  <= set_addr;
            link_valid <= !(snoop_valid && (snoop_addr == set_addr));
        end else if (clear || (snoop_valid && (snoop_addr == link_addr))) begin
            link_valid <= 1'b0;
        end
    end

    assign match = link_valid && (link_addr == match_addr);

endmodule

// File: rtl/mem_request_unit.sv
// rtl/mem_request_unit.sv - data memory request FSM with LL/SC link; STALL_COUNT_EN adds stall_cycles
module mem_request_unit
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              halt,
    input  logic [5:0]        mem_op,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              snoop_valid,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              dhit_eff,
    output logic [WORD_W-1:0] sc_result,
    output logic              req_busy
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    reqstate_t         state;
    opcode_t           req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              sc_res_q;
    logic              sc_fail_pulse;

    opcode_t           op_in;
    logic              complete;
    logic              link_match;
    logic              link_set;
    logic              link_clear;
    logic              sc_success;
    logic [ADDR_W-1:0] match_addr;

    assign op_in      = opcode_t'(mem_op);
    assign complete   = ((state == DREAD) || (state == DWRITE)) && dhit;
    assign sc_success = complete && (state == DWRITE) && (req_op == SC);

    // IDLE checks the incoming SC; a pending SW checks its own latched address.
    assign match_addr = (state == IDLE) ? mem_addr : req_addr;
    assign link_set   = complete && (state == DREAD) && (req_op == LL);
    assign link_clear = sc_success ||
                        (complete && (state == DWRITE) && (req_op == SW) && link_match);

    link_reg #(.ADDR_W(ADDR_W)) u_link (
        .clk        (CLK),
        .rst        (RST),
        .set        (link_set),
        .set_addr   (req_addr),
        .clear      (link_clear),
        .snoop_valid(snoop_valid),
        .snoop_addr (snoop_addr),
        .match_addr (match_addr),
        .match      (link_match)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            req_op        <= NOP;
            req_addr      <= '0;
            sc_res_q      <= 1'b0;
            sc_fail_pulse <= 1'b0;
        end else begin
            sc_fail_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (halt) begin
                        state <= HALTED;
                    end else if (is_read_op(op_in)) begin
                        state    <= DREAD;
                        req_op   <= op_in;
                        req_addr <= mem_addr;
                    end else if (op_in == SW) begin
                        state    <= DWRITE;
                        req_op   <= op_in;
                        req_addr <= mem_addr;
                    end else if (op_in == SC) begin
                        req_op   <= op_in;
                        req_addr <= mem_addr;
                        if (link_match) begin
                            state <= DWRITE;
                        end else begin
                            // Local fail: complete without touching memory.
                            state         <= DONE;
                            sc_fail_pulse <= 1'b1;
                            sc_res_q      <= 1'b0;
                        end
                    end
                end
                DREAD, DWRITE: begin
                    if (dhit) begin
                        if (sc_success) sc_res_q <= 1'b1;
                        state <= ihit ? IDLE : DONE;
                    end
                end
                DONE: begin
                    if (ihit) state <= IDLE;
                end
                HALTED: state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

    assign dREN      = (state == DREAD);
    assign dWEN      = (state == DWRITE);
    assign req_busy  = dREN || dWEN;
    assign iREN      = (state != HALTED);
    assign dhit_eff  = complete || sc_fail_pulse;
    assign sc_result = {{(WORD_W-1){1'b0}}, (sc_success || sc_res_q)};

`ifdef STALL_COUNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles <= '0;
        end else if (req_busy && !dhit && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_request_unit.sv
// tb/tb_mem_request_unit.sv - directed vectors, corner sequences and random run against a reference model
module tb_mem_request_unit;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST, ihit, dhit, halt, snoop_valid;
    logic [5:0]  mem_op;
    logic [31:0] mem_addr, snoop_addr;
    logic        iREN, dREN, dWEN, dhit_eff, req_busy;
    logic [31:0] sc_result;
`ifdef STALL_COUNT_EN
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_request_unit dut (
        .CLK        (CLK),
        .RST        (RST),
        .ihit       (ihit),
        .dhit       (dhit),
        .halt       (halt),
        .mem_op     (mem_op),
        .mem_addr   (mem_addr),
        .snoop_valid(snoop_valid),
        .snoop_addr (snoop_addr),
        .iREN       (iREN),
        .dREN       (dREN),
        .dWEN       (dWEN),
        .dhit_eff   (dhit_eff),
        .sc_result  (sc_result),
        .req_busy   (req_busy)
`ifdef STALL_COUNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    typedef struct {
        logic        rst, ih, dh, hl;
        logic [5:0]  op;
        logic [31:0] addr;
        logic        dren, dwen, iren, dhe, scr;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input logic r, ih, dh, hl, input logic [5:0] op, input logic [31:0] ad,
                     input logic dren, dwen, iren, dhe, scr);
        vec_t t;
        t.rst = r; t.ih = ih; t.dh = dh; t.hl = hl; t.op = op; t.addr = ad;
        t.dren = dren; t.dwen = dwen; t.iren = iren; t.dhe = dhe; t.scr = scr;
        tbl.push_back(t);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic cyc(input logic r, ih, dh, hl, input logic [5:0] op, input logic [31:0] ad,
                       input logic sv, input logic [31:0] sa);
        @(posedge CLK);
        #1;
        RST = r; ihit = ih; dhit = dh; halt = hl; mem_op = op; mem_addr = ad;
        snoop_valid = sv; snoop_addr = sa;
        #4;
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", n, act, exp);
        end
    endtask

    task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, act, exp);
        end
    endtask

    task automatic outs(input string n, input logic dren, dwen, iren, dhe, input logic [31:0] scr);
        chk1({n, ".dREN"}, dREN, dren);
        chk1({n, ".dWEN"}, dWEN, dwen);
        chk1({n, ".iREN"}, iREN, iren);
        chk1({n, ".dhit_eff"}, dhit_eff, dhe);
        chk1({n, ".req_busy"}, req_busy, dren | dwen);
        chk32({n, ".sc_result"}, sc_result, scr);
    endtask

    // Reference model: pending read/write flags, a wait-for-ihit flag and a link record.
    bit          m_halt, m_rd, m_wr, m_wait, m_pulse, m_sc, m_lv;
    logic [5:0]  m_op;
    logic [31:0] m_addr, m_la;

    task automatic model_reset();
        m_halt = 0; m_rd = 0; m_wr = 0; m_wait = 0; m_pulse = 0; m_sc = 0; m_lv = 0;
        m_op = NOP; m_addr = '0; m_la = '0;
    endtask

    task automatic model_step(input logic r, ih, dh, hl, input logic [5:0] op, input logic [31:0] ad,
                              input logic sv, input logic [31:0] sa);
        bit pulse_next, set_link, kill;
        pulse_next = 0; set_link = 0; kill = 0;
        if (r) begin
            model_reset();
            return;
        end
        if (!m_halt) begin
            if (m_rd || m_wr) begin
                if (dh) begin
                    if (m_rd && m_op == LL) set_link = 1;
                    if (m_wr && m_op == SC) begin m_sc = 1; kill = 1; end
                    if (m_wr && m_op == SW && m_addr == m_la) kill = 1;
                    m_rd = 0; m_wr = 0; m_wait = !ih;
                end
            end else if (m_wait) begin
                if (ih) m_wait = 0;
            end else if (hl) begin
                m_halt = 1;
            end else if (op == LW || op == LL || op == SW || op == SC) begin
                m_op = op; m_addr = ad;
                if (op == LW || op == LL) m_rd = 1;
                else if (op == SW) m_wr = 1;
                else if (m_lv && m_la == ad) m_wr = 1;
                else begin pulse_next = 1; m_sc = 0; m_wait = 1; end
            end
        end
        if (set_link) begin
            m_la = m_addr;
            m_lv = !(sv && sa == m_addr);
        end else if (kill || (sv && sa == m_la)) begin
            m_lv = 0;
        end
        m_pulse = pulse_next;
    endtask

    initial begin
        logic [31:0] addrs [4];
        logic        r, ih, dh, hl, sv;
        logic [5:0]  op;
        logic [31:0] ad, sa;
        logic [1:0]  ai;

        addrs[0] = 32'h80; addrs[1] = 32'h84; addrs[2] = 32'h100; addrs[3] = 32'h8000_0080;
        RST = 1; ihit = 0; dhit = 0; halt = 0; mem_op = NOP; mem_addr = '0;
        snoop_valid = 0; snoop_addr = '0;

        //   rst ih dh hl op    addr       dren dwen iren dhe scr
        v(1, 0, 0, 0, NOP, 32'h0,    0, 0, 1, 0, 0);
        v(0, 0, 0, 0, LW,  32'h40,   0, 0, 1, 0, 0);
        v(0, 0, 0, 0, LW,  32'h40,   1, 0, 1, 0, 0);
        v(0, 0, 0, 0, LW,  32'h40,   1, 0, 1, 0, 0);
        v(0, 0, 1, 0, LW,  32'h40,   1, 0, 1, 1, 0);
        v(0, 0, 0, 0, LW,  32'h40,   0, 0, 1, 0, 0);
        v(0, 1, 0, 0, LW,  32'h40,   0, 0, 1, 0, 0);
        v(0, 0, 0, 0, NOP, 32'h40,   0, 0, 1, 0, 0);
        v(0, 0, 0, 0, NOP, 32'h40,   0, 0, 1, 0, 0);
        v(0, 0, 0, 0, LL,  32'h80,   0, 0, 1, 0, 0);
        v(0, 1, 1, 0, LL,  32'h80,   1, 0, 1, 1, 0);
        v(0, 0, 0, 0, SC,  32'h80,   0, 0, 1, 0, 0);
        v(0, 0, 0, 0, SC,  32'h80,   0, 1, 1, 0, 0);
        v(0, 1, 1, 0, SC,  32'h80,   0, 1, 1, 1, 1);
        v(0, 0, 0, 0, NOP, 32'h0,    0, 0, 1, 0, 1);
        v(0, 0, 0, 0, SC,  32'h80,   0, 0, 1, 0, 1);
        v(0, 0, 0, 0, SC,  32'h80,   0, 0, 1, 1, 0);
        v(0, 1, 0, 0, NOP, 32'h0,    0, 0, 1, 0, 0);
        v(0, 0, 0, 0, NOP, 32'h0,    0, 0, 1, 0, 0);
        v(0, 0, 0, 0, SW,  32'h100,  0, 0, 1, 0, 0);
        v(0, 1, 1, 0, SW,  32'h100,  0, 1, 1, 1, 0);
        v(0, 0, 0, 0, LW,  32'h104,  0, 0, 1, 0, 0);
        v(0, 1, 1, 0, LW,  32'h104,  1, 0, 1, 1, 0);
        v(0, 0, 0, 0, NOP, 32'h0,    0, 0, 1, 0, 0);

        cyc(1, 0, 0, 0, NOP, 32'h0, 0, 32'h0);
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].ih, tbl[i].dh, tbl[i].hl, tbl[i].op, tbl[i].addr, 0, 32'h0);
            outs($sformatf("vec%0d", i), tbl[i].dren, tbl[i].dwen, tbl[i].iren, tbl[i].dhe,
                 {31'b0, tbl[i].scr});
        end

        // Snoop after LL kills the following SC.
        cyc(0, 0, 0, 0, LL,  32'h80, 0, 32'h0);
        cyc(0, 1, 1, 0, LL,  32'h80, 0, 32'h0);  chk1("snp.ll_dhe", dhit_eff, 1);
        cyc(0, 0, 0, 0, NOP, 32'h0,  1, 32'h80);
        cyc(0, 0, 0, 0, SC,  32'h80, 0, 32'h0);  chk1("snp.sc_idle_dwen", dWEN, 0);
        cyc(0, 0, 0, 0, NOP, 32'h0,  0, 32'h0);  outs("snp.sc_fail", 0, 0, 1, 1, 32'h0);
        cyc(0, 1, 0, 0, NOP, 32'h0,  0, 32'h0);  chk1("snp.done_dhe", dhit_eff, 0);

        // Snoop on the LL dhit cycle wins over the link set.
        cyc(0, 0, 0, 0, LL,  32'h80, 0, 32'h0);
        cyc(0, 1, 1, 0, LL,  32'h80, 1, 32'h80); chk1("coll.ll_dhe", dhit_eff, 1);
        cyc(0, 0, 0, 0, SC,  32'h80, 0, 32'h0);
        cyc(0, 1, 0, 0, NOP, 32'h0,  0, 32'h0);  outs("coll.sc_fail", 0, 0, 1, 1, 32'h0);
        cyc(0, 0, 0, 0, NOP, 32'h0,  0, 32'h0);  outs("coll.after", 0, 0, 1, 0, 32'h0);

        // Snoop to a different address leaves the link intact.
        cyc(0, 0, 0, 0, LL,  32'h80, 0, 32'h0);
        cyc(0, 1, 1, 0, LL,  32'h80, 1, 32'h84);
        cyc(0, 0, 0, 0, SC,  32'h80, 0, 32'h0);
        cyc(0, 1, 1, 0, SC,  32'h80, 0, 32'h0);  outs("other.sc_ok", 0, 1, 1, 1, 32'h1);

        // SC decided in IDLE while a snoop clears the link: the SC still issues.
        cyc(0, 0, 0, 0, LL,  32'h80, 0, 32'h0);
        cyc(0, 1, 1, 0, LL,  32'h80, 0, 32'h0);
        cyc(0, 0, 0, 0, SC,  32'h80, 1, 32'h80);
        cyc(0, 1, 1, 0, SC,  32'h80, 0, 32'h0);  outs("race.sc_ok", 0, 1, 1, 1, 32'h1);

        // Halt is terminal.
        cyc(0, 0, 0, 1, HALT, 32'h0, 0, 32'h0);  chk1("halt.iren_pre", iREN, 1);
        cyc(0, 0, 0, 0, LW,  32'h40, 0, 32'h0);  outs("halt.lw", 0, 0, 0, 0, 32'h1);
        cyc(0, 1, 1, 0, LW,  32'h40, 0, 32'h0);  outs("halt.dhit", 0, 0, 0, 0, 32'h1);
        cyc(0, 0, 0, 0, LW,  32'h40, 0, 32'h0);  chk1("halt.dren", dREN, 0);

        // Reset in the middle of a read.
        cyc(1, 0, 0, 0, NOP, 32'h0,  0, 32'h0);
        cyc(0, 0, 0, 0, LW,  32'h40, 0, 32'h0);  outs("rst.idle", 0, 0, 1, 0, 32'h0);
        cyc(0, 0, 0, 0, LW,  32'h40, 0, 32'h0);  chk1("rst.dren_up", dREN, 1);
        cyc(1, 0, 0, 0, LW,  32'h40, 0, 32'h0);  chk1("rst.dren_pre", dREN, 1);
        cyc(0, 0, 0, 0, NOP, 32'h0,  0, 32'h0);  outs("rst.after", 0, 0, 1, 0, 32'h0);
        cyc(0, 0, 0, 0, NOP, 32'h0,  0, 32'h0);  chk1("rst.no_reissue", dREN, 0);

        // Random traffic against the model.
        cyc(1, 0, 0, 0, NOP, 32'h0, 0, 32'h0);
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] e_scr;
            r  = ($urandom_range(0, 59) == 0);
            ih = ($urandom_range(0, 1) == 0);
            dh = ($urandom_range(0, 2) == 0);
            hl = ($urandom_range(0, 149) == 0);
            sv = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 8))
                0, 1:    op = LW;
                2, 3:    op = SW;
                4, 5:    op = LL;
                6, 7:    op = SC;
                default: op = NOP;
            endcase
            ai = 2'($urandom_range(0, 3)); ad = addrs[ai];
            ai = 2'($urandom_range(0, 3)); sa = addrs[ai];
            cyc(r, ih, dh, hl, op, ad, sv, sa);
            e_scr = {31'b0, (m_wr && m_op == SC && dh) ? 1'b1 : m_sc};
            outs($sformatf("rnd%0d", n), m_rd, m_wr, !m_halt,
                 ((m_rd || m_wr) && dh) || m_pulse, e_scr);
            model_step(r, ih, dh, hl, op, ad, sv, sa);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_request_unit.md
Name: mem_request_unit

Overview:
- Issues data-memory requests for the instruction held in the EX/MEM latch and holds each request until dhit.
- Suppresses re-issue while the pipeline is frozen waiting for ihit.
- Owns the LL/SC link register, with snoop invalidation.
- Produces dhit_eff, which the hazard unit and EX/MEM/MEM/WB latches consume for enable/flush; sits directly upstream of the hazard unit.

Parameters:
ADDR_W, 32, data address width
WORD_W, 32, data word width

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
ihit  in  1  instruction memory hit, pipeline advance strobe
dhit  in  1  data memory hit
halt  in  1  HALT instruction reached MEM stage
mem_op  in  6  opcode_t of EX/MEM instruction
mem_addr  in  ADDR_W  effective data address from EX/MEM
snoop_valid  in  1  coherence invalidation valid
snoop_addr  in  ADDR_W  invalidated address
iREN  out  1  instruction read enable
dREN  out  1  data read request
dWEN  out  1  data write request
dhit_eff  out  1  data op complete (real dhit, or local SC fail)
sc_result  out  WORD_W  SC writeback value: 1 success, 0 fail
req_busy  out  1  request outstanding (DREAD or DWRITE)

Behaviour:
- Clock and reset: single clock CLK. Reset RST is synchronous, active-high.
- Reset values, applied at the next edge with RST=1:
  - state=IDLE
  - iREN=1, dREN=0, dWEN=0, dhit_eff=0, sc_result=0, req_busy=0
  - link_valid=0, link_addr=0
- Outputs are Moore-decoded from state:
  - dREN=(state==DREAD)
  - dWEN=(state==DWRITE)
  - req_busy=dREN|dWEN
  - iREN=(state!=HALTED)
- At issue (leaving IDLE), op and addr are latched into req_op/req_addr. mem_op/mem_addr changes are ignored until the unit returns to IDLE.
- IDLE transitions, in priority order:
  - halt -> HALTED
  - LW/LL -> DREAD
  - SW -> DWRITE
  - SC with link_valid && link_addr==mem_addr -> DWRITE
  - SC otherwise -> DONE, with dhit_eff=1 for that cycle and sc_result=0
  - other ops -> stay in IDLE
- Request latency: dREN/dWEN rise one cycle after the op is presented.
- DREAD, on dhit:
  - dhit_eff=dhit (combinational).
  - If req_op==LL: link_valid<=1, link_addr<=req_addr.
  - Go to DONE; if ihit is also high that cycle, go directly to IDLE.
- DWRITE, on dhit:
  - dhit_eff=1.
  - If req_op==SC: sc_result=1 and link_valid<=0.
  - If req_op==SW and req_addr==link_addr: link_valid<=0.
  - Next state as for DREAD (DONE, or IDLE if ihit is also high).
- DONE: dREN=dWEN=0, dhit_eff=0. On ihit -> IDLE. This prevents a duplicate access while EX/MEM is frozen.
- sc_result holds its value until the next SC completes.
- Snoop invalidation: snoop_valid && snoop_addr==link_addr clears link_valid.
  - If this coincides with an LL dhit and snoop_addr==req_addr, the snoop wins: link_valid ends 0.
  - A snoop that clears the link in the same cycle an SC is decided in IDLE does not affect that SC; the IDLE check uses pre-edge link state.
- HALTED: terminal until RST. iREN=0; no data requests.
- RST asserted mid-request: the request is abandoned and all outputs take reset values at that edge.
- Address compare is a full ADDR_W equality; there is no word-offset masking.

Optional Feature:
- Macro: STALL_COUNT_EN.
- Defined:
  - Adds output stall_cycles (32 bits, reset 0).
  - Increments each cycle req_busy=1 && dhit=0; saturates at 0xFFFFFFFF.
  - Clears only on RST.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- cpu_types_pkg:
  - opcode_t (LW, SW, LL, SC, HALT already present)
  - word_t
  - new enum reqstate_t {IDLE, DREAD, DWRITE, DONE, HALTED}
- Sub-module link_reg:
  - holds link_valid/link_addr
  - inputs: set (with addr), clear, snoop_valid/snoop_addr
  - output: match(addr)
- The top level holds the FSM and request latch.

Test Plan:
- LW 0x0000_0040, dhit asserted 3 cycles after dREN, ihit 2 cycles later -> dREN high exactly 3 cycles, one dhit_eff pulse, DONE held 2 cycles, no second dREN.
- LL 0x80 completes, then SC 0x80 -> link_valid=1 after LL; SC raises dWEN; on dhit sc_result=1 and link_valid=0.
- LL 0x80, snoop_valid with snoop_addr=0x80, then SC 0x80 -> no dWEN; dhit_eff pulses one cycle after the op is presented; sc_result=0.
- LL 0x80 dhit in the same cycle as snoop 0x80 -> link_valid=0; a following SC 0x80 fails.
- SW 0x100 with dhit and ihit in the same cycle, next op LW 0x104 -> DWRITE->IDLE->DREAD; dREN rises 2 cycles after the SW dhit.
- halt in IDLE -> iREN=0 next cycle; LW presented afterwards gives no dREN; RST raised mid-DREAD on another run -> dREN=0 and state IDLE at that edge.
